// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the sync_fifo_ctrl FIFO family.
package sync_fifo_pkg;

    typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

    localparam int unsigned FIFO_MAX_DEPTH = 4096;

    // Advance a pointer, wrapping at depth-1 by compare so any depth works.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int unsigned depth);
        return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Distributed-RAM style storage: synchronous write, asynchronous read, no reset.
module fifo_mem #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with arbitrary depth, standard or FWFT read mode, thresholds and sticky errors.
// Define SYNC_FIFO_WATERMARK_EN to add the wm_clr input and max_count peak-occupancy output.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FWFT       = 0,
    parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    input  logic [CNT_W-1:0]      af_thresh,
    input  logic [CNT_W-1:0]      ae_thresh,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
`ifdef SYNC_FIFO_WATERMARK_EN
    ,
    input  logic                  wm_clr,
    output logic [CNT_W-1:0]      max_count
`endif
);

    localparam int unsigned      PTR_W   = $clog2(DEPTH);
    localparam fifo_mode_e       MODE    = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  af_q, af_d, ae_q, ae_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;

    logic [DATA_WIDTH-1:0] mem_rdata_c;
    logic [CNT_W-1:0]      mem_cnt_c;
    logic                  full_c, empty_c, wr_acc_c, rd_acc_c, mem_empty_c;

    assign full_c   = (count_q == DEPTH_C);
    // In FWFT the output register holds the head, so emptiness is its valid bit.
    assign empty_c  = (MODE == FIFO_FWFT) ? !rd_valid_q : (count_q == '0);
    assign wr_acc_c = wr_en && !full_c;
    assign rd_acc_c = rd_en && !empty_c;

    // Entries still in the RAM (count also covers the FWFT output register).
    assign mem_cnt_c   = (MODE == FIFO_FWFT) ? (count_q - CNT_W'(rd_valid_q)) : count_q;
    assign mem_empty_c = (mem_cnt_c == '0);

    fifo_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_acc_c),
        .waddr_i (wptr_q),
        .wdata_i (wr_data),
        .raddr_i (rptr_q),
        .rdata_o (mem_rdata_c)
    );

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        count_d    = count_q + CNT_W'(wr_acc_c) - CNT_W'(rd_acc_c);

        if (wr_acc_c) begin
            wptr_d = PTR_W'(ptr_inc(32'(wptr_q), DEPTH));
        end

        if (MODE == FIFO_FWFT) begin
            rd_valid_d = rd_valid_q && !rd_acc_c;
            // Refill the output register whenever it is free or being popped.
            if ((!rd_valid_q || rd_acc_c) && !mem_empty_c) begin
                rd_data_d  = mem_rdata_c;
                rd_valid_d = 1'b1;
                rptr_d     = PTR_W'(ptr_inc(32'(rptr_q), DEPTH));
            end
        end else if (rd_acc_c) begin
            rd_data_d  = mem_rdata_c;
            rd_valid_d = 1'b1;
            rptr_d     = PTR_W'(ptr_inc(32'(rptr_q), DEPTH));
        end

        af_d  = (count_d >= af_thresh);
        ae_d  = (count_d <= ae_thresh);
        // A new error in the same cycle as clr_err keeps the flag set.
        ovf_d = (wr_en && full_c) || (ovf_q && !clr_err);
        unf_d = (rd_en && empty_c) || (unf_q && !clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign empty        = empty_c;
    assign full         = full_c;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

`ifdef SYNC_FIFO_WATERMARK_EN
    logic [CNT_W-1:0] max_q, max_d;

    // Peak occupancy tracker; wm_clr restarts it from the upcoming count.
    always_comb begin
        max_d = max_q;
        if (wm_clr) begin
            max_d = count_d;
        end else if (count_d > max_q) begin
            max_d = count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

    assign max_count = max_q;
`endif

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Second-generation single-clock FIFO: arbitrary depth (not limited to powers of two), standard or first-word-fall-through (FWFT) read mode, run-time almost-full/almost-empty thresholds, exact occupancy count, and sticky overflow/underflow flags.
- Drop-in buffer between streaming pipeline stages in the same clock domain.
- Storage is distributed RAM: synchronous write, asynchronous read.

Parameters:
- DEPTH, 16, number of entries; any value 2..4096.
- DATA_WIDTH, 32, width of each entry in bits.
- FWFT, 0, read mode: 0 = standard (1-cycle read latency), 1 = first-word-fall-through.
- CNT_W, $clog2(DEPTH+1), width of count and threshold ports; derived, never overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; all state is cleared while low.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read request (standard mode) or pop/acknowledge (FWFT mode).
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_data is valid.
- empty  out  1  no entry is readable.
- full  out  1  count == DEPTH.
- af_thresh  in  CNT_W  almost-full threshold.
- ae_thresh  in  CNT_W  almost-empty threshold.
- almost_full  out  1  registered flag: count >= af_thresh.
- almost_empty  out  1  registered flag: count <= ae_thresh.
- count  out  CNT_W  registered occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: a write was attempted while full.
- underflow  out  1  sticky flag: a read was attempted while empty.
- clr_err  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset values:
  - rd_data = 0, rd_valid = 0, count = 0.
  - empty = 1, full = 0.
  - almost_full = 0, almost_empty = 1.
  - overflow = 0, underflow = 0.
  - Both pointers = 0.
- Pointers:
  - wptr and rptr each range 0..DEPTH-1.
  - Each increments on its accepted operation and wraps from DEPTH-1 to 0 by explicit compare, not by modulo width.
- Write acceptance:
  - wr_acc = wr_en && !full.
  - Entry is written at wptr on the clock edge.
  - A write attempted while full is dropped: the memory and wptr are unchanged, and overflow is set on the next edge.
- Count:
  - count_next = count + wr_acc - rd_acc.
  - Simultaneous accepted read and write leave count unchanged.
  - full = (count == DEPTH) combinationally from the count register.
- Standard mode (FWFT = 0):
  - rd_acc = rd_en && !empty.
  - empty = (count == 0).
  - On rd_acc, rd_data <= mem[rptr] and rd_valid <= 1 one cycle later; otherwise rd_valid <= 0 and rd_data holds its value.
  - rd_en while empty: no pointer change, underflow is set.
  - A write to an empty FIFO is readable from the following cycle.
- FWFT mode (FWFT = 1):
  - The output register is part of the storage. The head entry is presented on rd_data with rd_valid = 1 without any request.
  - empty = !rd_valid.
  - rd_acc = rd_en && rd_valid (pop).
  - On a pop, the output register refills from memory in the same edge if the memory is non-empty; otherwise rd_valid drops to 0.
  - A write to a completely empty FIFO appears with rd_valid = 1 one cycle after the write edge. The write cycle is N; rd_valid rises at N+1.
  - Total capacity is DEPTH entries: memory entries plus the output register. count includes the output register.
  - rd_en while rd_valid = 0 sets underflow.
- Flags:
  - almost_full <= (count_next >= af_thresh) and almost_empty <= (count_next <= ae_thresh), so both flags update on the same edge as count.
  - Threshold changes take effect on the next edge.
  - af_thresh = 0 forces almost_full = 1.
  - ae_thresh >= DEPTH forces almost_empty = 1.
- Sticky errors:
  - Set on the offending attempt and held until clr_err.
  - If clr_err and a new error occur in the same cycle, set wins.
- Reset mid-operation:
  - Contents are discarded, the FIFO immediately reads empty, and all outputs take their reset values asynchronously.
- Memory contents are not reset and never observable while invalid.

Optional Feature:
- Macro SYNC_FIFO_WATERMARK_EN.
- When defined:
  - Adds input wm_clr (1 bit) and output max_count (CNT_W bits).
  - max_count is the peak count since reset or the last wm_clr; reset value 0.
  - max_count <= (count_next > max_count) ? count_next : max_count.
  - wm_clr loads max_count with count_next.
- When undefined:
  - Neither port exists and no register is inferred.

Decomposition:
- Package sync_fifo_pkg:
  - typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e.
  - Function ptr_inc(ptr, depth) implementing the wrap compare.
  - Constant FIFO_MAX_DEPTH = 4096.
- Sub-module fifo_mem:
  - Parameters DEPTH and DATA_WIDTH.
  - Synchronous write port, asynchronous read port.
  - No reset on the storage array.

Test Plan:
- DEPTH = 5, FWFT = 0: write 0x11..0x55, then a 6th write of 0x66 → full = 1, count = 5, overflow = 1. Reading 5 times returns 0x11..0x55, each with rd_valid = 1 one cycle after rd_en, and 0x66 never appears.
- DEPTH = 5, FWFT = 1: single write of 0xA5 at cycle N → rd_data = 0xA5 and rd_valid = 1 at N+1, empty = 0. Pop → rd_valid = 0, count = 0.
- DEPTH = 7: 20 cycles of simultaneous wr_en/rd_en at half-full (count = 3) → count stays 3, data order is preserved across the pointer wrap at 6 → 0.
- af_thresh = 4, ae_thresh = 1, DEPTH = 8: fill one entry per cycle → almost_empty falls on the edge where count goes 1 → 2, almost_full rises where count goes 3 → 4.
- rd_en on an empty FIFO → underflow = 1 and held. clr_err pulse → 0. clr_err together with a new underflow → stays 1.
- rst_n asserted mid-fill (count = 3) between clock edges → outputs immediately take their reset values (empty = 1, count = 0). After release, the first read returns the first newly written word.
